// File: rtl/hmr_pkg.sv
// Shared types and helpers for the TMR recovery controller.
package hmr_pkg;

  localparam int CoresPerTMRGroup = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    SETBACK = 3'd2,
    RESUME  = 3'd3,
    FAULT   = 3'd4
  } hmr_rec_state_e;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/hmr_tmr_recovery_fsm.sv
// Recovery sequencer for one 3-core TMR group: drain, setback, resume, or sticky fault.
module hmr_tmr_recovery_fsm
  import hmr_pkg::*;
#(
  parameter int SetbackCycles = 8,
  parameter int DrainTimeout  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [2:0] error_cba_i,
  input  logic       drained_i,
  input  logic       fatal_clr_i,
  output logic       stall_o,
  output logic [2:0] setback_o,
  output logic       busy_o,
  output logic       recovered_o,
  output logic       fatal_o,
  output logic [2:0] cnt_inc_o
);

  localparam int TimerMax = (DrainTimeout > SetbackCycles) ? DrainTimeout : SetbackCycles;
  localparam int TimerW   = $clog2(TimerMax + 1);

  hmr_rec_state_e    state_reg, state_next;
  logic [2:0]        mask_reg, mask_next, merged;
  logic [TimerW-1:0] timer_reg, timer_next;

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    timer_next = timer_reg;
    merged     = mask_reg | error_cba_i;
    case (state_reg)
      IDLE: begin
        if (enable_i && |error_cba_i) begin
          mask_next  = error_cba_i;
          timer_next = '0;
          state_next = (popcnt3(error_cba_i) >= 2'd2) ? FAULT : DRAIN;
        end
      end
      DRAIN: begin
        mask_next  = merged;
        timer_next = timer_reg + 1'b1;
        // A second faulty core leaves no majority, so it beats a same-cycle drain.
        if (popcnt3(merged) >= 2'd2) begin
          state_next = FAULT;
        end else if (drained_i) begin
          state_next = SETBACK;
          timer_next = '0;
        end else if (timer_reg == TimerW'(DrainTimeout - 1)) begin
          state_next = FAULT;
        end
      end
      SETBACK: begin
        if (timer_reg == TimerW'(SetbackCycles - 1)) state_next = RESUME;
        else timer_next = timer_reg + 1'b1;
      end
      RESUME: begin
        state_next = IDLE;
        mask_next  = '0;
      end
      FAULT: begin
        if (fatal_clr_i) begin
          state_next = IDLE;
          mask_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        mask_next  = '0;
      end
    endcase
  end

  // Counter increments fire on the transition into SETBACK or FAULT only.
  assign cnt_inc_o = ((state_next == SETBACK || state_next == FAULT) && state_next != state_reg)
                     ? mask_next : 3'b000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      timer_reg   <= '0;
      stall_o     <= 1'b0;
      setback_o   <= '0;
      busy_o      <= 1'b0;
      recovered_o <= 1'b0;
      fatal_o     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      timer_reg   <= timer_next;
      stall_o     <= (state_next != IDLE);
      setback_o   <= (state_next == SETBACK) ? mask_next : 3'b000;
      busy_o      <= (state_next != IDLE);
      recovered_o <= (state_next == RESUME);
      fatal_o     <= (state_next == FAULT);
    end
  end

endmodule

// File: rtl/hmr_tmr_recovery_ctrl.sv
// Per-group TMR recovery controller; HMR_TMR_ERR_CNT_EN adds saturating per-core error counters.
module hmr_tmr_recovery_ctrl
  import hmr_pkg::*;
#(
  parameter int NumTMRGroups  = 4,
  parameter int SetbackCycles = 8,
  parameter int DrainTimeout  = 256,
  parameter int CntWidth      = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic [NumTMRGroups-1:0]                                enable_i,
  input  logic [NumTMRGroups-1:0][CoresPerTMRGroup-1:0]          error_cba_i,
  input  logic [NumTMRGroups-1:0]                                drained_i,
  input  logic [NumTMRGroups-1:0]                                fatal_clr_i,
  output logic [NumTMRGroups-1:0]                                stall_o,
  output logic [CoresPerTMRGroup*NumTMRGroups-1:0]               core_setback_o,
  output logic [NumTMRGroups-1:0]                                busy_o,
  output logic [NumTMRGroups-1:0]                                recovered_o,
  output logic [NumTMRGroups-1:0]                                fatal_o,
  output logic [CoresPerTMRGroup*NumTMRGroups-1:0][CntWidth-1:0] err_cnt_o,
  input  logic                                                   cnt_clr_i
);

  localparam int NumCores = CoresPerTMRGroup * NumTMRGroups;

  logic [NumCores-1:0] cnt_inc;

  for (genvar gi = 0; gi < NumTMRGroups; gi++) begin : g_grp
    hmr_tmr_recovery_fsm #(
      .SetbackCycles(SetbackCycles),
      .DrainTimeout (DrainTimeout)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_i[gi]),
      .error_cba_i(error_cba_i[gi]),
      .drained_i  (drained_i[gi]),
      .fatal_clr_i(fatal_clr_i[gi]),
      .stall_o    (stall_o[gi]),
      .setback_o  (core_setback_o[CoresPerTMRGroup*gi +: CoresPerTMRGroup]),
      .busy_o     (busy_o[gi]),
      .recovered_o(recovered_o[gi]),
      .fatal_o    (fatal_o[gi]),
      .cnt_inc_o  (cnt_inc[CoresPerTMRGroup*gi +: CoresPerTMRGroup])
    );
  end

`ifdef HMR_TMR_ERR_CNT_EN
  for (genvar gi = 0; gi < NumCores; gi++) begin : g_cnt
    logic [CntWidth-1:0] cnt_reg;
    // Clear beats a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                             cnt_reg <= '0;
      else if (cnt_clr_i)                    cnt_reg <= '0;
      else if (cnt_inc[gi] && !(&cnt_reg))   cnt_reg <= cnt_reg + 1'b1;
    end
    assign err_cnt_o[gi] = cnt_reg;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr_i, cnt_inc};
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hmr_tmr_recovery_ctrl.sv
// Directed, table-driven bench for hmr_tmr_recovery_ctrl (4 groups, 8 setback cycles, 256 drain timeout).
module tb_hmr_tmr_recovery_ctrl;

  typedef struct {
    logic [3:0]  en;
    logic [11:0] err;
    logic [3:0]  drn;
    logic [3:0]  clr;
    logic [3:0]  stall;
    logic [11:0] sb;
    logic [3:0]  rec;
    logic [3:0]  fat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       en_v = '0;
  logic [3:0][2:0]  err_v = '0;
  logic [3:0]       drn_v = '0;
  logic [3:0]       clr_v = '0;
  logic             cnt_clr_v = 1'b0;
  logic [3:0]       stall, busy, rec, fat;
  logic [11:0]      sb;
  logic [11:0][7:0] cnt;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  hmr_tmr_recovery_ctrl #(
    .NumTMRGroups(4), .SetbackCycles(8), .DrainTimeout(256), .CntWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en_v), .error_cba_i(err_v),
    .drained_i(drn_v), .fatal_clr_i(clr_v), .stall_o(stall),
    .core_setback_o(sb), .busy_o(busy), .recovered_o(rec), .fatal_o(fat),
    .err_cnt_o(cnt), .cnt_clr_i(cnt_clr_v)
  );

`ifdef HMR_TMR_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // busy must track stall: both mean "group not IDLE"
  task automatic check_outs(input string name, input logic [3:0] e_stall, input logic [11:0] e_sb,
                            input logic [3:0] e_rec, input logic [3:0] e_fat);
    check(name, {stall, sb, busy, rec, fat}, {e_stall, e_sb, e_stall, e_rec, e_fat});
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [11:0] err, input logic [3:0] drn,
                              input logic [3:0] clr, input logic [3:0] st, input logic [11:0] s,
                              input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    v.en = en; v.err = err; v.drn = drn; v.clr = clr;
    v.stall = st; v.sb = s; v.rec = r; v.fat = f;
    return v;
  endfunction

  initial begin
    // Group 0 single-core error on core 1, drained immediately
    tbl.push_back(mk(4'hF, 12'h002, 4'h1, 4'h0, 4'h1, 12'h000, 4'h0, 4'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(4'hF, 12'h000, 4'h1, 4'h0, 4'h1, 12'h002, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 12'h000, 4'h1, 4'h0, 4'h1, 12'h000, 4'h1, 4'h0));
    tbl.push_back(mk(4'hF, 12'h000, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0));
    // Group 1 double-core error -> immediate FAULT, drain ignored, cleared by fatal_clr
    tbl.push_back(mk(4'hF, 12'h018, 4'h0, 4'h0, 4'h2, 12'h000, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 12'h000, 4'h2, 4'h0, 4'h2, 12'h000, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 12'h000, 4'h2, 4'h0, 4'h2, 12'h000, 4'h0, 4'h2));
    tbl.push_back(mk(4'hF, 12'h000, 4'h0, 4'h2, 4'h0, 12'h000, 4'h0, 4'h0));
    // Group 2 disabled: error ignored
    tbl.push_back(mk(4'hB, 12'h100, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0));
    tbl.push_back(mk(4'hB, 12'h100, 4'h4, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0));
    // Group 3 core a error, then core c during DRAIN -> FAULT
    tbl.push_back(mk(4'hF, 12'h200, 4'h0, 4'h0, 4'h8, 12'h000, 4'h0, 4'h0));
    tbl.push_back(mk(4'hF, 12'h800, 4'h0, 4'h0, 4'h8, 12'h000, 4'h0, 4'h8));
    tbl.push_back(mk(4'hF, 12'h000, 4'h0, 4'h8, 4'h0, 12'h000, 4'h0, 4'h0));
    // Group 2 core b error, enable dropped mid-sequence: recovery still completes
    tbl.push_back(mk(4'hF, 12'h080, 4'h0, 4'h0, 4'h4, 12'h000, 4'h0, 4'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(4'h0, 12'h000, 4'h4, 4'h0, 4'h4, 12'h080, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 12'h000, 4'h4, 4'h0, 4'h4, 12'h000, 4'h4, 4'h0));
    tbl.push_back(mk(4'h0, 12'h000, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0));

    // Reset state
    tick();
    check_outs("reset_outs", 4'h0, 12'h000, 4'h0, 4'h0);
    check("reset_cnt", cnt[0] | cnt[5] | cnt[11], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      en_v = tbl[i].en; err_v = tbl[i].err; drn_v = tbl[i].drn; clr_v = tbl[i].clr;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].stall, tbl[i].sb, tbl[i].rec, tbl[i].fat);
    end
    en_v = 4'hF; err_v = '0; drn_v = '0; clr_v = '0;

    // Drain timeout: 256 DRAIN cycles then FAULT
    err_v = 12'h001;
    tick();
    err_v = '0;
    check_outs("tmo_enter", 4'h1, 12'h000, 4'h0, 4'h0);
    begin
      int bad = 0;
      for (int i = 0; i < 255; i++) begin
        tick();
        if (fat[0] !== 1'b0 || stall[0] !== 1'b1) bad++;
      end
      check("tmo_hold_bad_cycles", bad, 0);
    end
    tick();
    check_outs("tmo_fault", 4'h1, 12'h000, 4'h0, 4'h1);
    clr_v = 4'h1;
    tick();
    clr_v = '0;
    check_outs("tmo_clr", 4'h0, 12'h000, 4'h0, 4'h0);

    // Drain on the final timeout cycle wins over the timeout
    err_v = 12'h001;
    tick();
    err_v = '0;
    repeat (255) tick();
    drn_v = 4'h1;
    tick();
    drn_v = '0;
    check_outs("tmo_drain_wins", 4'h1, 12'h001, 4'h0, 4'h0);
    repeat (10) tick();
    check_outs("tmo_drain_idle", 4'h0, 12'h000, 4'h0, 4'h0);

    // Asynchronous reset mid-setback
    err_v = 12'h001; drn_v = 4'h1;
    tick();
    err_v = '0;
    tick();
    check_outs("pre_rst_setback", 4'h1, 12'h001, 4'h0, 4'h0);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 4'h0, 12'h000, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_outs("post_rst_idle", 4'h0, 12'h000, 4'h0, 4'h0);

    // Error counters: 300 recoveries on core 0 saturate at 255
    cnt_clr_v = 1'b1;
    tick();
    cnt_clr_v = 1'b0;
    check("cnt_clr_initial", cnt[0], 32'd0);
    for (int i = 0; i < 300; i++) begin
      err_v = 12'h001; drn_v = 4'h1;
      tick();
      err_v = '0;
      repeat (11) tick();
      if (i == 99) check("cnt_100", cnt[0], CntEn ? 32'd100 : 32'd0);
    end
    check("cnt_sat", cnt[0], CntEn ? 32'd255 : 32'd0);
    check("cnt_other_core", cnt[1], 32'd0);
    cnt_clr_v = 1'b1;
    tick();
    cnt_clr_v = 1'b0;
    check("cnt_clr", cnt[0], 32'd0);
    // Clear on the same edge as the SETBACK-entry increment
    err_v = 12'h001;
    tick();
    err_v = '0;
    cnt_clr_v = 1'b1;
    tick();
    cnt_clr_v = 1'b0;
    check("cnt_clr_wins", cnt[0], 32'd0);
    repeat (10) tick();
    check("cnt_after_recovery", cnt[0], 32'd0);
    drn_v = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
